// File: rtl/axi_mem_responder.sv
// AXI4 INCR-burst memory responder: independent write (AW/W/B) and read (AR/R) FSMs over one word-wide memory.
// Define AXI_MEM_RESP_RANGE_CHK_EN to reject beats beyond DEPTH instead of wrapping the word index.
module axi_mem_responder #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 128,
    parameter int ID_W   = 6,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2
) (
    input  logic                io_aclk,
    input  logic                io_areset,
    input  logic                awvalid,
    output logic                awready,
    input  logic [ID_W-1:0]     awid,
    input  logic [ADDR_W-1:0]   awaddr,
    input  logic [7:0]          awlen,
    input  logic                wvalid,
    output logic                wready,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic                wlast,
    output logic                bvalid,
    input  logic                bready,
    output logic [ID_W-1:0]     bid,
    output logic [1:0]          bresp,
    input  logic                arvalid,
    output logic                arready,
    input  logic [ID_W-1:0]     arid,
    input  logic [ADDR_W-1:0]   araddr,
    input  logic [7:0]          arlen,
    output logic                rvalid,
    input  logic                rready,
    output logic [ID_W-1:0]     rid,
    output logic [DATA_W-1:0]   rdata,
    output logic [1:0]          rresp,
    output logic                rlast
);
    localparam int STRB_W  = DATA_W / 8;
    localparam int BYTE_SH = $clog2(STRB_W);
    localparam int IDX_W   = $clog2(DEPTH);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [3:0] LAT_LAST    = 4'((RD_LAT > 0) ? RD_LAT - 1 : 0);

`ifdef AXI_MEM_RESP_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    logic [DATA_W-1:0] mem_q [DEPTH];

    // Without the range check every word index is legal and simply wraps modulo DEPTH.
    function automatic logic idx_ok(input logic [ADDR_W-1:0] idx);
        return !RANGE_CHK || ((idx >> IDX_W) == '0);
    endfunction

    w_state_e          w_state_q, w_state_d;
    logic [ID_W-1:0]   w_id_q, w_id_d;
    logic [ADDR_W-1:0] w_idx_q, w_idx_d;
    logic [7:0]        w_len_q, w_len_d, w_cnt_q, w_cnt_d;
    logic              w_err_q, w_err_d;
    logic              w_beat, w_last_beat;

    assign awready     = (w_state_q == W_IDLE) && !io_areset;
    assign wready      = (w_state_q == W_DATA);
    assign bvalid      = (w_state_q == W_RESP);
    assign bid         = w_id_q;
    assign bresp       = (bvalid && w_err_q) ? RESP_SLVERR : RESP_OKAY;
    assign w_beat      = wready && wvalid;
    assign w_last_beat = (w_cnt_q == w_len_q);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        w_state_d = w_state_q;
        w_id_d    = w_id_q;
        w_idx_d   = w_idx_q;
        w_len_d   = w_len_q;
        w_cnt_d   = w_cnt_q;
        w_err_d   = w_err_q;
        unique case (w_state_q)
            W_IDLE: if (awvalid && awready) begin
                w_id_d    = awid;
                w_idx_d   = awaddr >> BYTE_SH;
                w_len_d   = awlen;
                w_cnt_d   = '0;
                w_err_d   = 1'b0;
                w_state_d = W_DATA;
            end
            W_DATA: if (w_beat) begin
                w_cnt_d = w_cnt_q + 8'd1;
                w_idx_d = w_idx_q + ADDR_W'(1);
                w_err_d = w_err_q | (wlast != w_last_beat) | !idx_ok(w_idx_q);
                if (w_last_beat) w_state_d = W_RESP;
            end
            W_RESP: if (bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase
    end

    always_ff @(posedge io_aclk or posedge io_areset) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (io_areset) begin
            w_state_q <= W_IDLE;
            w_id_q    <= '0;
            w_idx_q   <= '0;
            w_len_q   <= '0;
            w_cnt_q   <= '0;
            w_err_q   <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            w_id_q    <= w_id_d;
            w_idx_q   <= w_idx_d;
            w_len_q   <= w_len_d;
            w_cnt_q   <= w_cnt_d;
            w_err_q   <= w_err_d;
        end
    end

    // NOTE: the memory array is deliberately left out of reset so its contents survive io_areset.
    always_ff @(posedge io_aclk) begin
        if (w_beat && idx_ok(w_idx_q)) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) mem_q[w_idx_q[IDX_W-1:0]][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    r_state_e          r_state_q, r_state_d;
    logic [ID_W-1:0]   r_id_q, r_id_d;
    logic [ADDR_W-1:0] r_idx_q, r_idx_d, rd_load_idx;
    logic [7:0]        r_len_q, r_len_d, r_cnt_q, r_cnt_d;
    logic [3:0]        r_lat_q, r_lat_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        rresp_q, rresp_d;
    logic              rd_load, r_last;

    assign arready = (r_state_q == R_IDLE) && !io_areset;
    assign rvalid  = (r_state_q == R_DATA);
    assign r_last  = (r_cnt_q == r_len_q);
    assign rlast   = rvalid && r_last;
    assign rid     = r_id_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

    always_comb begin
        r_state_d   = r_state_q;
        r_id_d      = r_id_q;
        r_idx_d     = r_idx_q;
        r_len_d     = r_len_q;
        r_cnt_d     = r_cnt_q;
        r_lat_d     = r_lat_q;
        rd_load     = 1'b0;
        rd_load_idx = r_idx_q;
        unique case (r_state_q)
            R_IDLE: if (arvalid && arready) begin
                r_id_d  = arid;
                r_idx_d = araddr >> BYTE_SH;
                r_len_d = arlen;
                r_cnt_d = '0;
                r_lat_d = '0;
                if (RD_LAT == 0) begin
                    r_state_d   = R_DATA;
                    rd_load     = 1'b1;
                    rd_load_idx = araddr >> BYTE_SH;
                end else begin
                    r_state_d = R_WAIT;
                end
            end
            R_WAIT: if (r_lat_q == LAT_LAST) begin
                r_state_d = R_DATA;
                rd_load   = 1'b1;
            end else begin
                r_lat_d = r_lat_q + 4'd1;
            end
            R_DATA: if (rready) begin
                if (r_last) begin
                    r_state_d = R_IDLE;
                end else begin
                    r_cnt_d     = r_cnt_q + 8'd1;
                    r_idx_d     = r_idx_q + ADDR_W'(1);
                    rd_load     = 1'b1;
                    rd_load_idx = r_idx_q + ADDR_W'(1);
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        // Beat data is captured once when it becomes valid, so later writes cannot disturb a stalled beat.
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (rd_load) begin
            if (idx_ok(rd_load_idx)) begin
                rdata_d = mem_q[rd_load_idx[IDX_W-1:0]];
                rresp_d = RESP_OKAY;
            end else begin
                rdata_d = '0;
                rresp_d = RESP_SLVERR;
            end
        end
    end

    always_ff @(posedge io_aclk or posedge io_areset) begin
        if (io_areset) begin
            r_state_q <= R_IDLE;
            r_id_q    <= '0;
            r_idx_q   <= '0;
            r_len_q   <= '0;
            r_cnt_q   <= '0;
            r_lat_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= '0;
        end else begin
            r_state_q <= r_state_d;
            r_id_q    <= r_id_d;
            r_idx_q   <= r_idx_d;
            r_len_q   <= r_len_d;
            r_cnt_q   <= r_cnt_d;
            r_lat_q   <= r_lat_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi_mem_responder.sv
// Scoreboard bench for axi_mem_responder: expected B/R results are queued at stimulus time and checked by negedge monitors.
module tb_axi_mem_responder;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 128;
    localparam int ID_W   = 6;
    localparam int DEPTH  = 4096;
    localparam int RD_LAT = 2;
    localparam int STRB_W = DATA_W / 8;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

`ifdef AXI_MEM_RESP_RANGE_CHK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    logic                io_aclk = 1'b0;
    logic                io_areset;
    logic                awvalid, awready, wvalid, wready, wlast;
    logic [ID_W-1:0]     awid, arid, bid, rid;
    logic [ADDR_W-1:0]   awaddr, araddr;
    logic [7:0]          awlen, arlen;
    logic [DATA_W-1:0]   wdata, rdata;
    logic [STRB_W-1:0]   wstrb;
    logic                bvalid, bready, arvalid, arready, rvalid, rready, rlast;
    logic [1:0]          bresp, rresp;

    always #5 io_aclk = ~io_aclk;

    axi_mem_responder #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
    ) dut (
        .io_aclk(io_aclk), .io_areset(io_areset),
        .awvalid(awvalid), .awready(awready), .awid(awid), .awaddr(awaddr), .awlen(awlen),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .arid(arid), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast)
    );

    typedef struct {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } r_beat_t;

    typedef struct {
        logic [ID_W-1:0] id;
        logic [1:0]      resp;
    } b_resp_t;

    r_beat_t           r_exp[$];
    b_resp_t           b_exp[$];
    r_beat_t           re;
    b_resp_t           be;
    logic [DATA_W-1:0] model_mem [DEPTH];
    int                checks = 0;
    int                errors = 0;

    // Monitors: a handshake seen at negedge completes on the following rising edge.
    always @(negedge io_aclk) begin
        if (rvalid && rready) begin
            checks++;
            if (r_exp.size() == 0) begin
                errors++;
                $display("FAIL r_unexpected: got rvalid=1 rid=%0h rdata=%0h, required no beat", rid, rdata);
            end else begin
                re = r_exp.pop_front();
                if ({rid, rdata, rresp, rlast} !== {re.id, re.data, re.resp, re.last}) begin
                    errors++;
                    $display("FAIL r_beat: got id=%0h data=%0h resp=%0d last=%0b, required id=%0h data=%0h resp=%0d last=%0b",
                             rid, rdata, rresp, rlast, re.id, re.data, re.resp, re.last);
                end
            end
        end
        if (bvalid && bready) begin
            checks++;
            if (b_exp.size() == 0) begin
                errors++;
                $display("FAIL b_unexpected: got bvalid=1 bid=%0h, required no response", bid);
            end else begin
                be = b_exp.pop_front();
                if ({bid, bresp} !== {be.id, be.resp}) begin
                    errors++;
                    $display("FAIL b_resp: got id=%0h resp=%0d, required id=%0h resp=%0d", bid, bresp, be.id, be.resp);
                end
            end
        end
    end

    task automatic tick();
        @(posedge io_aclk);
        #1;
    endtask

    function automatic logic model_ok(input logic [ADDR_W-1:0] idx);
        return !RANGE_CHK || (idx < ADDR_W'(DEPTH));
    endfunction

    task automatic do_aw(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        int n = 0;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        @(negedge io_aclk);
        while (!awready && n < 200) begin @(negedge io_aclk); n++; end
        checks++;
        if (!awready) begin errors++; $display("FAIL aw_timeout: got awready=0, required 1"); end
        @(posedge io_aclk); #1;
        awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [DATA_W-1:0] data, input logic [STRB_W-1:0] strb, input logic last);
        int n = 0;
        wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
        @(negedge io_aclk);
        while (!wready && n < 200) begin @(negedge io_aclk); n++; end
        checks++;
        if (!wready) begin errors++; $display("FAIL w_timeout: got wready=0, required 1"); end
        @(posedge io_aclk); #1;
        wvalid = 1'b0; wlast = 1'b0;
    endtask

    task automatic do_ar(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        int n = 0;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        @(negedge io_aclk);
        while (!arready && n < 200) begin @(negedge io_aclk); n++; end
        checks++;
        if (!arready) begin errors++; $display("FAIL ar_timeout: got arready=0, required 1"); end
        @(posedge io_aclk); #1;
        arvalid = 1'b0;
    endtask

    // Update the reference memory for a write burst and queue its expected B response.
    task automatic write_model(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                               input logic [DATA_W-1:0] base, input logic [STRB_W-1:0] strb, input int wlast_beat);
        logic [ADDR_W-1:0] idx;
        logic [DATA_W-1:0] d;
        b_resp_t           b;
        b.id = id;
        b.resp = (wlast_beat != int'(len)) ? SLVERR : OKAY;
        for (int k = 0; k <= int'(len); k++) begin
            idx = (addr >> 4) + ADDR_W'(k);
            d = base + DATA_W'(k);
            if (!model_ok(idx)) b.resp = SLVERR;
            else for (int i = 0; i < STRB_W; i++) if (strb[i]) model_mem[idx % DEPTH][i*8 +: 8] = d[i*8 +: 8];
        end
        b_exp.push_back(b);
    endtask

    task automatic write_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len,
                               input logic [DATA_W-1:0] base, input logic [STRB_W-1:0] strb, input int wlast_beat);
        write_model(id, addr, len, base, strb, wlast_beat);
        do_aw(id, addr, len);
        for (int k = 0; k <= int'(len); k++) do_w(base + DATA_W'(k), strb, k == wlast_beat);
    endtask

    task automatic read_exp(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        logic [ADDR_W-1:0] idx;
        r_beat_t           r;
        for (int k = 0; k <= int'(len); k++) begin
            idx = (addr >> 4) + ADDR_W'(k);
            r.id = id;
            r.last = (k == int'(len));
            if (model_ok(idx)) begin r.data = model_mem[idx % DEPTH]; r.resp = OKAY; end
            else begin r.data = '0; r.resp = SLVERR; end
            r_exp.push_back(r);
        end
    endtask

    task automatic read_burst(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr, input logic [7:0] len);
        read_exp(id, addr, len);
        do_ar(id, addr, len);
    endtask

    task automatic drain(input string what);
        int n = 0;
        while ((r_exp.size() != 0 || b_exp.size() != 0) && n < 500) begin tick(); n++; end
        checks++;
        if (r_exp.size() != 0 || b_exp.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d R and %0d B outstanding, required 0", what, r_exp.size(), b_exp.size());
            r_exp.delete(); b_exp.delete();
        end
    endtask

    task automatic test_reset();
        io_areset = 1'b1;
        awvalid = 0; wvalid = 0; arvalid = 0; wlast = 0; bready = 1; rready = 1;
        awid = '0; awaddr = '0; awlen = '0; wdata = '0; wstrb = '0; arid = '0; araddr = '0; arlen = '0;
        repeat (3) tick();
        checks++;
        if ({awready, wready, bvalid, arready, rvalid, rlast} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got aw/w/b/ar/r/last=%b, required 000000",
                     {awready, wready, bvalid, arready, rvalid, rlast});
        end
        checks++;
        if ({bid, rid, bresp, rresp} !== '0) begin
            errors++;
            $display("FAIL reset_ids: got bid=%0h rid=%0h bresp=%0d rresp=%0d, required all 0", bid, rid, bresp, rresp);
        end
        checks++;
        if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %0h, required 0", rdata); end
        io_areset = 1'b0;
        #1;
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++;
            $display("FAIL reset_release: got awready=%b arready=%b, required 1 1", awready, arready);
        end
    endtask

    task automatic test_write_burst();
        write_burst(6'd5, 32'h100, 8'd3, 128'hA0, '1, 3);
        checks++;
        if ({bvalid, bid} !== {1'b1, 6'd5}) begin
            errors++;
            $display("FAIL b_timing: got bvalid=%b bid=%0h after last beat, required bvalid=1 bid=5", bvalid, bid);
        end
        drain("write_burst");
    endtask

    task automatic test_read_burst();
        int lat = 1;
        rready = 1'b1;
        read_burst(6'd7, 32'h100, 8'd3);
        while (!rvalid && lat < 20) begin tick(); lat++; end
        checks++;
        if (lat != RD_LAT + 1) begin
            errors++;
            $display("FAIL read_latency: got first rvalid %0d cycles after AR, required %0d", lat, RD_LAT + 1);
        end
        drain("read_burst");
    endtask

    task automatic test_read_stall();
        int n = 0;
        rready = 1'b0;
        read_burst(6'd9, 32'h100, 8'd3);
        while (!rvalid && n < 20) begin tick(); n++; end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        write_burst(6'd2, 32'h110, 8'd0, 128'hFF, '1, 0);
        for (int c = 0; c < 4; c++) begin
            tick();
            checks++;
            if ({rvalid, rdata, rid, rlast} !== {1'b1, 128'hA1, 6'd9, 1'b0}) begin
                errors++;
                $display("FAIL stall_hold: got valid=%b data=%0h id=%0h last=%b, required valid=1 data=a1 id=9 last=0",
                         rvalid, rdata, rid, rlast);
            end
        end
        rready = 1'b1;
        drain("read_stall");
    endtask

    task automatic test_wlast_err();
        write_burst(6'd3, 32'h200, 8'd1, 128'hB0, '1, 0);
        write_burst(6'd4, 32'h220, 8'd1, 128'hB8, '1, -1);
        drain("wlast_write");
        read_burst(6'd3, 32'h200, 8'd1);
        drain("wlast_read0");
        read_burst(6'd4, 32'h220, 8'd1);
        drain("wlast_read1");
    endtask

    task automatic test_strobe();
        write_burst(6'd1, 32'h500, 8'd0, {16{8'h11}}, '1, 0);
        write_burst(6'd1, 32'h500, 8'd0, {16{8'h22}}, 16'h00F0, 0);
        drain("strobe_write");
        read_burst(6'd1, 32'h500, 8'd0);
        drain("strobe_read");
    endtask

    task automatic test_range();
        write_burst(6'd6, 32'h0, 8'd0, 128'h1234, '1, 0);
        write_burst(6'd6, 32'h10, 8'd0, 128'h9999, '1, 0);
        write_burst(6'd6, ADDR_W'(DEPTH * 16 + 16), 8'd0, 128'h5678, '1, 0);
        drain("range_write");
        read_burst(6'd6, ADDR_W'(DEPTH * 16), 8'd1);
        drain("range_read_hi");
        read_burst(6'd6, 32'h10, 8'd0);
        drain("range_read_lo");
    endtask

    task automatic test_concurrent();
        read_exp(6'd10, 32'h500, 8'd0);
        write_model(6'd11, 32'h600, 8'd1, 128'hD0, '1, 1);
        awid = 6'd11; awaddr = 32'h600; awlen = 8'd1; awvalid = 1'b1;
        arid = 6'd10; araddr = 32'h500; arlen = 8'd0; arvalid = 1'b1;
        @(negedge io_aclk);
        checks++;
        if ({awready, arready} !== 2'b11) begin
            errors++;
            $display("FAIL concurrent_ready: got awready=%b arready=%b, required 1 1", awready, arready);
        end
        tick();
        awvalid = 1'b0; arvalid = 1'b0;
        checks++;
        if ({awready, arready} !== 2'b00) begin
            errors++;
            $display("FAIL concurrent_accept: got awready=%b arready=%b after handshake, required 0 0", awready, arready);
        end
        do_w(128'hD0, '1, 1'b0);
        do_w(128'hD1, '1, 1'b1);
        drain("concurrent");
        read_burst(6'd11, 32'h600, 8'd1);
        drain("concurrent_read");
    endtask

    task automatic test_reset_mid();
        int n = 0;
        write_burst(6'd12, 32'h300, 8'd3, 128'hC0, '1, 3);
        drain("mid_write");
        rready = 1'b0;
        read_burst(6'd13, 32'h300, 8'd3);
        while (!rvalid && n < 20) begin tick(); n++; end
        rready = 1'b1;
        tick();
        tick();
        rready = 1'b0;
        io_areset = 1'b1;
        #1;
        checks++;
        if ({rvalid, rlast, arready, awready} !== 4'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rvalid=%b rlast=%b arready=%b awready=%b rdata=%0h, required all 0",
                     rvalid, rlast, arready, awready, rdata);
        end
        checks++;
        if (r_exp.size() != 2) begin
            errors++;
            $display("FAIL mid_reset_beats: got %0d beats pending, required 2", r_exp.size());
        end
        r_exp.delete();
        tick();
        tick();
        read_exp(6'd14, 32'h300, 8'd3);
        arid = 6'd14; araddr = 32'h300; arlen = 8'd3; arvalid = 1'b1;
        io_areset = 1'b0;
        tick();
        arvalid = 1'b0;
        checks++;
        if (arready !== 1'b0) begin
            errors++;
            $display("FAIL ar_after_reset: got arready=%b one cycle after release, required 0 (AR taken)", arready);
        end
        rready = 1'b1;
        drain("mid_reread");
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_burst();
        test_read_stall();
        test_wlast_err();
        test_strobe();
        test_range();
        test_concurrent();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
